// File: rtl/peri_timer_irq.sv
// Timer / interrupt-source peripheral: down-counter with auto-reload, 64-bit mtime, soft and masked external IRQs.
// Latency: one cycle from an accepted request to peri_ready/peri_rdata; irq_bitmap lags its sources by one cycle.
// Backpressure: none; every hit is acked one cycle later, and the cycle after an ack the held request is ignored.
module peri_timer_irq #(
  parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
  parameter int          IRQ_TIMER_BIT = 7,
  parameter int          IRQ_SOFT_LSB  = 3,
  parameter logic [63:0] MTIME_INIT    = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        peri_rden,
  input  logic        peri_wren,
  input  logic [31:0] peri_addr,
  input  logic [31:0] peri_wdata,
  input  logic [3:0]  peri_wstrb,
  output logic [31:0] peri_rdata,
  output logic        peri_ready,
  input  logic [31:0] ext_irq,
  output logic [31:0] irq_bitmap
);

  // Word offsets inside the 256-byte window (byte offset >> 2).
  localparam logic [5:0] OFF_CTRL     = 6'h00;
  localparam logic [5:0] OFF_LOAD     = 6'h01;
  localparam logic [5:0] OFF_COUNT    = 6'h02;
  localparam logic [5:0] OFF_STATUS   = 6'h03;
  localparam logic [5:0] OFF_MTIME_LO = 6'h04;
  localparam logic [5:0] OFF_MTIME_HI = 6'h05;
  localparam logic [5:0] OFF_SOFT     = 6'h06;
  localparam logic [5:0] OFF_EXT_MASK = 6'h07;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Architectural state
  logic        ctrl_en;
  logic        ctrl_autoreload;
  logic        ctrl_tirq_en;
  logic [31:0] load_q;
  logic [31:0] count_q;
  logic        expired_q;
  logic [3:0]  soft_q;
  logic [31:0] ext_mask_q;
  logic [63:0] mtime_q;
  logic [31:0] mtime_hi_shadow;

  // Bus decode
  logic        hit;
  logic        req;
  logic        acc;
  logic        wr_acc;
  logic        rd_acc;
  logic [5:0]  word;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_count;
  logic        wr_status;
  logic        wr_soft;
  logic        wr_ext_mask;
  logic        rd_mtime_lo;
  logic [31:0] rd_mux;

  // Timer next-state
  logic        expire;
  logic [31:0] count_next;
  logic        en_next;
  logic        autoreload_next;
  logic        tirq_en_next;
  logic        expired_next;

  logic [31:0] irq_next;

  // Byte-lane select bits of the address are intentionally not decoded.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^peri_addr[1:0];

  // Address decode and single-shot accept: a request is taken only when no ack is outstanding.
  always_comb begin
    hit         = (peri_addr[31:8] == BASE_ADDR[31:8]);
    req         = (peri_rden | peri_wren) & hit;
    acc         = req & ~peri_ready;
    wr_acc      = acc & peri_wren;
    rd_acc      = acc & peri_rden;
    word        = peri_addr[7:2];
    wr_ctrl     = wr_acc && (word == OFF_CTRL);
    wr_load     = wr_acc && (word == OFF_LOAD);
    wr_count    = wr_acc && (word == OFF_COUNT);
    wr_status   = wr_acc && (word == OFF_STATUS);
    wr_soft     = wr_acc && (word == OFF_SOFT);
    wr_ext_mask = wr_acc && (word == OFF_EXT_MASK);
    rd_mtime_lo = rd_acc && (word == OFF_MTIME_LO);
  end

  // Read mux; unmapped offsets return zero.
  always_comb begin
    rd_mux = '0;
    case (word)
      OFF_CTRL:     rd_mux = {29'b0, ctrl_tirq_en, ctrl_autoreload, ctrl_en};
      OFF_LOAD:     rd_mux = load_q;
      OFF_COUNT:    rd_mux = count_q;
      OFF_STATUS:   rd_mux = {31'b0, expired_q};
      OFF_MTIME_LO: rd_mux = mtime_q[31:0];
      OFF_MTIME_HI: rd_mux = mtime_hi_shadow;
      OFF_SOFT:     rd_mux = {28'b0, soft_q};
      OFF_EXT_MASK: rd_mux = ext_mask_q;
      default:      rd_mux = '0;
    endcase
  end

  // Timer step: CPU writes to COUNT/CTRL take priority over hardware updates; expiry beats W1C.
  always_comb begin
    expire          = ctrl_en && (count_q == 32'd0);
    count_next      = count_q;
    en_next         = ctrl_en;
    autoreload_next = ctrl_autoreload;
    tirq_en_next    = ctrl_tirq_en;
    expired_next    = expired_q;

    if (wr_count) begin
      count_next = merge_bytes(count_q, peri_wdata, peri_wstrb);
    end else if (ctrl_en) begin
      if (count_q != 32'd0)  count_next = count_q - 32'd1;
      else if (ctrl_autoreload) count_next = load_q;
      else                   count_next = 32'd0;
    end

    if (wr_ctrl && peri_wstrb[0]) begin
      en_next         = peri_wdata[0];
      autoreload_next = peri_wdata[1];
      tirq_en_next    = peri_wdata[2];
    end else if (expire && !ctrl_autoreload) begin
      en_next = 1'b0;
    end

    if (expire) begin
      expired_next = 1'b1;
    end else if (wr_status && peri_wstrb[0] && peri_wdata[0]) begin
      expired_next = 1'b0;
    end
  end

  // Interrupt vector: masked external lines, soft bits, and gated timer flag.
  always_comb begin
    irq_next = ext_irq & ext_mask_q;
    irq_next[IRQ_SOFT_LSB +: 4] = irq_next[IRQ_SOFT_LSB +: 4] | soft_q;
    irq_next[IRQ_TIMER_BIT]     = irq_next[IRQ_TIMER_BIT] | (expired_q & ctrl_tirq_en);
  end

  // Bus response: single-cycle ack with data, zero data while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peri_ready <= 1'b0;
      peri_rdata <= '0;
    end else begin
      peri_ready <= acc;
      peri_rdata <= acc ? rd_mux : 32'd0;
    end
  end

  // Timer control, counter and expiry flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en         <= 1'b0;
      ctrl_autoreload <= 1'b0;
      ctrl_tirq_en    <= 1'b0;
      count_q         <= '0;
      expired_q       <= 1'b0;
    end else begin
      ctrl_en         <= en_next;
      ctrl_autoreload <= autoreload_next;
      ctrl_tirq_en    <= tirq_en_next;
      count_q         <= count_next;
      expired_q       <= expired_next;
    end
  end

  // Plain software-owned configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q     <= '0;
      soft_q     <= '0;
      ext_mask_q <= '0;
    end else begin
      if (wr_load)                    load_q     <= merge_bytes(load_q, peri_wdata, peri_wstrb);
      if (wr_soft && peri_wstrb[0])   soft_q     <= peri_wdata[3:0];
      if (wr_ext_mask)                ext_mask_q <= merge_bytes(ext_mask_q, peri_wdata, peri_wstrb);
    end
  end

  // Free-running cycle counter; a LO read snapshots HI so the pair is read atomically.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime_q         <= MTIME_INIT;
      mtime_hi_shadow <= '0;
    end else begin
      mtime_q <= mtime_q + 64'd1;
      if (rd_mtime_lo) mtime_hi_shadow <= mtime_q[63:32];
    end
  end

  // Registered interrupt output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_bitmap <= '0;
    else       irq_bitmap <= irq_next;
  end

endmodule
